// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit load/clear/shift/rotate register with counted multi-step commands
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_dot,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, CLR} op_t;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    op_t mode_op, op, sel;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_q;
    logic step_so, multi, launch, last, apply_step;
    assign q_dot = ~q;
    assign mode_op = op_t'(mode);
    assign multi = !(mode_op == HOLD || mode_op == LOAD || mode_op == CLR);
    assign launch = state == IDLE && start;
    assign last = state == RUN && cnt == AMT_W'(1);
    // the start edge of a counted command only latches it; q moves on later edges
    assign apply_step = !(launch && multi);
    assign sel = state == RUN ? op : mode_op;
    always_comb begin
        step_q = q;
        step_so = serial_out;
        case (sel)
            LOAD: step_q = data;
            SHL: begin step_q = {q[WIDTH-2:0], serial_in}; step_so = q[WIDTH-1]; end
            SHR: begin step_q = {serial_in, q[WIDTH-1:1]}; step_so = q[0]; end
            ROL: begin step_q = {q[WIDTH-2:0], q[WIDTH-1]}; step_so = q[WIDTH-1]; end
            ROR: begin step_q = {q[0], q[WIDTH-1:1]}; step_so = q[0]; end
            ASR: begin step_q = {q[WIDTH-1], q[WIDTH-1:1]}; step_so = q[0]; end
            CLR: step_q = '0;
            default: step_q = q;
        endcase
    end
    always_comb begin
        state_next = state;
        if (launch && multi && amount != '0)
            state_next = RUN;
        else if (last)
            state_next = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op <= HOLD;
            cnt <= '0;
            q <= '0;
            serial_out <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_next;
            busy <= state_next == RUN;
            done <= (launch && (!multi || amount == '0)) || last;
            if (apply_step) begin
                q <= step_q;
                serial_out <= step_so;
            end
            if (launch && multi) begin
                op <= mode_op;
                cnt <= amount;
            end else if (state == RUN)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed vectors with hand-computed expectations for universal_shift_reg
module tb_universal_shift_reg;
    logic clock = 0, reset = 1, serial_in = 0, start = 0;
    logic [2:0] mode = 0;
    logic [7:0] data = 0;
    logic [3:0] amount = 0;
    logic [7:0] q, q_dot;
    logic serial_out, busy, done;
    int checks = 0, errors = 0;
    universal_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
        .clock(clock), .reset(reset), .mode(mode), .data(data), .serial_in(serial_in),
        .start(start), .amount(amount), .q(q), .q_dot(q_dot), .serial_out(serial_out),
        .busy(busy), .done(done)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    // launch a counted command and follow it until done, checking busy length and final q
    task automatic run_cmd(input string tag, input logic [2:0] m, input logic [3:0] n,
                           input logic [7:0] exp_q, input logic exp_so);
        int bc = 0;
        int dc = 0;
        int both = 0;
        mode = m; amount = n; start = 1;
        tick();
        start = 0; mode = 3'b001; data = 8'hFF;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) bc++;
            tick();
        end
        mode = 3'b000;
        if (done) dc = 1;
        if (done && busy) both = 1;
        check({tag, "_done"}, dc, 1);
        check({tag, "_busy_cycles"}, bc, n);
        check({tag, "_busy_done_overlap"}, both, 0);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_so"}, serial_out, exp_so);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
    endtask
    task automatic load(input logic [7:0] v);
        mode = 3'b001; data = v;
        tick();
        mode = 3'b000;
    endtask
    initial begin
        logic [7:0] exp;
        tick(); tick();
        check("rst_q", q, 8'h00);
        check("rst_qdot", q_dot, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_so", serial_out, 0);
        reset = 0;
        load(8'hA5);
        check("load_q", q, 8'hA5);
        check("load_qdot", q_dot, 8'h5A);
        tick(); tick(); tick();
        check("hold_q", q, 8'hA5);
        reset = 1;
        tick();
        check("rst_mid_q", q, 8'h00);
        reset = 0;
        // ROL x3 of 81 with load attempts ignored while busy
        load(8'h81);
        mode = 3'b100; amount = 3; start = 1;
        tick();
        check("rol_start_q", q, 8'h81);
        check("rol_start_busy", busy, 1);
        start = 0; mode = 3'b001; data = 8'hFF;
        tick();
        check("rol_s1", q, 8'h03);
        check("rol_s1_busy", busy, 1);
        tick();
        check("rol_s2", q, 8'h06);
        tick();
        check("rol_s3", q, 8'h0C);
        check("rol_busy_end", busy, 0);
        check("rol_done", done, 1);
        check("rol_so", serial_out, 0);
        mode = 3'b000;
        tick();
        check("rol_done_clr", done, 0);
        check("rol_hold", q, 8'h0C);
        // ASR saturation
        load(8'h80);
        run_cmd("asr7", 3'b110, 7, 8'hFF, 0);
        load(8'h80);
        run_cmd("asr15", 3'b110, 15, 8'hFF, 1);
        load(8'h01);
        run_cmd("ror9", 3'b101, 9, 8'h80, 1);
        load(8'h0F);
        mode = 3'b010; serial_in = 1;
        run_cmd("shl12", 3'b010, 12, 8'hFF, 1);
        // single-step SHR filling with ones
        mode = 3'b111;
        tick();
        check("clr_q", q, 8'h00);
        mode = 3'b011; serial_in = 1; exp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b1, exp[7:1]};
            check("shr_step", q, exp);
        end
        mode = 3'b010; serial_in = 0;
        tick();
        check("shl_q", q, 8'hFE);
        check("shl_so", serial_out, 1);
        // zero-amount command
        mode = 3'b010; amount = 0; start = 1;
        tick();
        start = 0; mode = 3'b000;
        check("amt0_q", q, 8'hFE);
        check("amt0_busy", busy, 0);
        check("amt0_done", done, 1);
        tick();
        check("amt0_done_clr", done, 0);
        check("amt0_q2", q, 8'hFE);
        // load issued as a command
        mode = 3'b001; data = 8'h3C; start = 1;
        tick();
        start = 0; mode = 3'b000;
        check("ldcmd_q", q, 8'h3C);
        check("ldcmd_done", done, 1);
        check("ldcmd_busy", busy, 0);
        // reset aborts an in-flight ROR
        mode = 3'b101; amount = 5; start = 1;
        tick();
        start = 0; mode = 3'b000;
        tick();
        check("abort_busy_pre", busy, 1);
        check("abort_q_pre", q, 8'h1E);
        reset = 1;
        tick();
        reset = 0;
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        // back-to-back command accepted in the done cycle
        load(8'h01);
        mode = 3'b100; amount = 2; start = 1;
        tick();
        start = 0; mode = 3'b000;
        tick(); tick();
        check("b2b_first_q", q, 8'h04);
        check("b2b_first_done", done, 1);
        mode = 3'b101; amount = 1; start = 1;
        tick();
        start = 0; mode = 3'b000;
        check("b2b_second_busy", busy, 1);
        check("b2b_second_done_low", done, 0);
        tick();
        check("b2b_second_q", q, 8'h02);
        check("b2b_second_done", done, 1);
        check("b2b_second_so", serial_out, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised multi-bit storage register built on the single-bit D storage element, generalised to a WIDTH-bit word.
- Supports parallel load, clear, logical shifts with serial in/out, rotates and arithmetic shift right.
- Supports multi-step shift/rotate commands sequenced by an internal counter with a busy/done handshake.
- Sits between datapath sources and consumers as a general shifter/holding register; keeps complementary q/q_dot outputs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the step-count input; maximum steps per command = 2^AMT_W-1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  3  operation select (encoding below).
- data  in  WIDTH  parallel load value.
- serial_in  in  1  fill bit for logical shifts.
- start  in  1  launch a command; sampled only when idle.
- amount  in  AMT_W  step count for a started shift/rotate.
- q  out  WIDTH  register contents.
- q_dot  out  WIDTH  always ~q (combinational).
- serial_out  out  1  registered last bit shifted or rotated out.
- busy  out  1  multi-step command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: q=0, q_dot=all ones, serial_out=0, busy=0, done=0, state=IDLE, counter=0.
- Reset aborts an in-flight command with no done pulse and has priority over every other input.
- mode encoding:
  - 000 hold.
  - 001 load (q<=data).
  - 010 SHL: q<={q[W-2:0],serial_in}, serial_out<=q[W-1].
  - 011 SHR: q<={serial_in,q[W-1:1]}, serial_out<=q[0].
  - 100 ROL, 101 ROR: serial_out takes the bit rotated out.
  - 110 ASR: MSB replicated, serial_out<=q[0].
  - 111 clear (q<=0).
  - serial_out is unchanged by hold/load/clear.
- IDLE, start=0: mode is applied once at every edge (single-step mode). The default is hold, so q is stable with mode=000.
- IDLE, start=1, mode is 000/001/111: the op executes once at that edge, done=1 in the following cycle, busy stays 0.
- IDLE, start=1, mode is 010..110:
  - The edge latches the op and amount; q is unchanged at that edge.
  - amount=0: done=1 next cycle, busy stays 0, stay in IDLE.
  - amount=N>0: busy<=1, counter<=N, go to RUN.
- RUN: each edge performs one step of the latched op and decrements counter.
  - On the edge where counter==1: busy<=0, done<=1, return to IDLE.
  - N steps therefore complete on edges 1..N after the start edge. busy is high for exactly N cycles; done is high in cycle N+1 only.
- While busy: mode, data, start and amount are ignored; serial_in is still sampled at each step.
- amount > WIDTH is legal. Rotates wrap modulo WIDTH. Logical shifts fill fully with serial_in. ASR saturates to the sign fill.
- start may be asserted in the done cycle; it is accepted as a new command (back-to-back).
- done and busy are never high in the same cycle.

Test Plan (WIDTH=8, AMT_W=4):
1. Assert reset 2 cycles -> q=00, q_dot=FF, busy=0, done=0, serial_out=0. Assert reset while q=A5 -> q=00 after the next edge.
2. mode=001, data=A5, start=0, one edge -> q=A5, q_dot=5A. Then mode=000 for 3 edges -> q stays A5.
3. q=81, mode=100, start=1, amount=3 -> busy for 3 cycles, q steps 03, 06, 0C; done pulses once; serial_out=0. During busy, drive mode=001, data=FF -> ignored, final q=0C.
4. q=80, mode=110, start=1, amount=7 -> after 7 steps q=FF, serial_out=0. Repeat with amount=15 -> q=FF, 15 busy cycles.
5. q=00, mode=011, serial_in=1, start=0 for 8 edges -> q=80, C0, … , FF. Then mode=010, serial_in=0, one edge -> q=FE, serial_out=1.
6. start with amount=0 -> done next cycle, busy never 1, q unchanged. Assert reset in cycle 2 of an amount=5 ROR -> q=00, busy=0, no done. Issue back-to-back starts in the done cycle -> second command accepted.
